// File: rtl/ntsc_timing_pkg.sv
// NTSC raster timing constants and strobe decoder shared by the sync generator.
// Exports DOTS/LINES, visible area, sync/burst windows and decode().
package ntsc_timing_pkg;

    localparam int DOTS        = 341;
    localparam int LINES       = 262;
    localparam int VIS_W       = 256;
    localparam int VIS_H       = 240;
    localparam int HSYNC_START = 277;
    localparam int HSYNC_END   = 301;
    localparam int BURST_START = 305;
    localparam int BURST_END   = 319;
    localparam int VSYNC_START = 244;
    localparam int VSYNC_END   = 246;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic blank;
        logic burst;
    } strobes_t;

    function automatic strobes_t decode(
        input logic [8:0] x,
        input logic [8:0] y
    );
        strobes_t s;
        logic     vs;
        logic     hs;
        logic     bw;
        vs = (y >= 9'(VSYNC_START)) && (y <= 9'(VSYNC_END));
        hs = (x >= 9'(HSYNC_START)) && (x <= 9'(HSYNC_END));
        bw = (x >= 9'(BURST_START)) && (x <= 9'(BURST_END));
        s.hsync_n = ~hs;
        s.vsync_n = ~vs;
        s.blank   = (x >= 9'(VIS_W)) || (y >= 9'(VIS_H));
        // burst is suppressed on the vertical sync lines
        s.burst   = bw & ~vs;
        return s;
    endfunction

endpackage

// File: rtl/ntsc_sync_gen_ce_divider.sv
// Modulo-N counter of input ticks producing a registered one-cycle enable.
// Ports: clk, reset (sync, high), tick in; ce out (registered), wrap (comb).
module ce_divider #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic ce,
    output logic wrap
);

    localparam int          W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    // wrap marks the tick that completes a period; it lets the owner update
    // state on the same edge that raises ce
    assign wrap = tick && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            ce    <= 1'b0;
        end else begin
            ce <= wrap;
            if (tick) begin
                count <= wrap ? '0 : count + W'(1);
            end
        end
    end

endmodule

// File: rtl/ntsc_sync_gen.sv
// NTSC dot/line raster generator with pixel and CPU clock enables.
// In: clk, reset, master_tick. Out: pix_ce, cpu_ce, dot_x, line_y, strobes.
module ntsc_sync_gen #(
    parameter int PIX_DIV = 4,
    parameter int CPU_DIV = 12,
    parameter int DOTS    = ntsc_timing_pkg::DOTS,
    parameter int LINES   = ntsc_timing_pkg::LINES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       master_tick,
    output logic       pix_ce,
    output logic       cpu_ce,
    output logic [8:0] dot_x,
    output logic [8:0] line_y,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank,
    output logic       burst,
    output logic       frame_start,
    output logic       odd_frame
);

    import ntsc_timing_pkg::*;

    localparam logic [8:0] LAST_DOT  = 9'(DOTS - 1);
    localparam logic [8:0] SKIP_DOT  = 9'(DOTS - 2);
    localparam logic [8:0] LAST_LINE = 9'(LINES - 1);

    logic       pix_wrap;
    logic       cpu_wrap_unused;
    logic [8:0] x_next;
    logic [8:0] y_next;
    logic [8:0] end_dot;
    logic       last_line;
    logic       frame_wrap;
    strobes_t   strb;

    ce_divider #(.N(PIX_DIV)) u_pix_div (
        .clk   (clk),
        .reset (reset),
        .tick  (master_tick),
        .ce    (pix_ce),
        .wrap  (pix_wrap)
    );

    ce_divider #(.N(CPU_DIV)) u_cpu_div (
        .clk   (clk),
        .reset (reset),
        .tick  (master_tick),
        .ce    (cpu_ce),
        .wrap  (cpu_wrap_unused)
    );

    always_comb begin
        last_line  = (line_y == LAST_LINE);
        end_dot    = LAST_DOT;
        x_next     = dot_x + 9'd1;
        y_next     = line_y;
        frame_wrap = 1'b0;
        // odd frames drop the final dot of the last line
        if (odd_frame && last_line) begin
            end_dot = SKIP_DOT;
        end
        if (dot_x == end_dot) begin
            x_next = '0;
            if (last_line) begin
                y_next     = '0;
                frame_wrap = 1'b1;
            end else begin
                y_next = line_y + 9'd1;
            end
        end
        strb = decode(x_next, y_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dot_x       <= '0;
            line_y      <= '0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            blank       <= 1'b0;
            burst       <= 1'b0;
            frame_start <= 1'b0;
            odd_frame   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_wrap) begin
                dot_x       <= x_next;
                line_y      <= y_next;
                hsync_n     <= strb.hsync_n;
                vsync_n     <= strb.vsync_n;
                blank       <= strb.blank;
                burst       <= strb.burst;
                frame_start <= frame_wrap;
                odd_frame   <= odd_frame ^ frame_wrap;
            end
        end
    end

endmodule

// File: tb/tb_ntsc_sync_gen.sv
// Scoreboard bench for ntsc_sync_gen: full-size raster plus a narrow-raster
// instance (12 dots/line, PIX_DIV=1) for whole-frame properties.
module tb_ntsc_sync_gen;

    localparam int PDIV = 4;
    localparam int CDIV = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       master_tick = 1'b0;

    logic       pix_ce, cpu_ce, hsync_n, vsync_n, blank, burst;
    logic       frame_start, odd_frame;
    logic [8:0] dot_x, line_y;

    logic       s_pix, s_cpu, s_hs, s_vs, s_blank, s_burst, s_fs, s_odd;
    logic [8:0] s_x, s_y;

    ntsc_sync_gen dut (
        .clk(clk), .reset(reset), .master_tick(master_tick),
        .pix_ce(pix_ce), .cpu_ce(cpu_ce), .dot_x(dot_x), .line_y(line_y),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .blank(blank), .burst(burst),
        .frame_start(frame_start), .odd_frame(odd_frame)
    );

    ntsc_sync_gen #(.PIX_DIV(1), .CPU_DIV(3), .DOTS(12), .LINES(262)) dut_s (
        .clk(clk), .reset(reset), .master_tick(master_tick),
        .pix_ce(s_pix), .cpu_ce(s_cpu), .dot_x(s_x), .line_y(s_y),
        .hsync_n(s_hs), .vsync_n(s_vs), .blank(s_blank), .burst(s_burst),
        .frame_start(s_fs), .odd_frame(s_odd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [8:0] x;
        logic [8:0] y;
        logic [5:0] flags;
    } exp_t;

    exp_t pq[$];
    int   cq[$];

    int checks = 0;
    int failures = 0;
    int nprint = 0;
    int cyc = 0;
    logic tick_q = 1'b0;
    logic rst_q = 1'b0;

    int pcnt = 0, ccnt = 0, k = 0;
    logic modd = 1'b0;

    int hs_low = 0, bu_hi = 0, pix_total = 0, idle_pix = 0;
    int len2 = 0, vs2 = 0, nfs2 = 0;
    int lens[8];
    int vsl[8];
    logic oddr[8];

    task automatic fail_line(input string name, input int got, input int exp);
        failures++;
        if (nprint < 40) begin
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
            nprint++;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) fail_line(name, got, exp);
    endtask

    task automatic advance();
        exp_t e;
        int   x, y;
        logic fs, hs_n, vs_n, bl, bu;
        fs = 1'b0;
        k++;
        if (k == (modd ? 89341 : 89342)) begin
            k = 0;
            modd = ~modd;
            fs = 1'b1;
        end
        x = k % 341;
        y = k / 341;
        hs_n = !(x >= 277 && x <= 301);
        vs_n = !(y >= 244 && y <= 246);
        bl = (x >= 256) || (y >= 240);
        bu = (x >= 305 && x <= 319) && vs_n;
        e.cyc = cyc + 1;
        e.x = 9'(x);
        e.y = 9'(y);
        e.flags = {hs_n, vs_n, bl, bu, fs, modd};
        pq.push_back(e);
    endtask

    task automatic step(input logic t, input logic r);
        master_tick = t;
        reset = r;
        if (r) begin
            pcnt = 0; ccnt = 0; k = 0; modd = 1'b0;
        end else if (t) begin
            if (pcnt == PDIV - 1) begin
                pcnt = 0;
                advance();
            end else pcnt++;
            if (ccnt == CDIV - 1) begin
                ccnt = 0;
                cq.push_back(cyc + 1);
            end else ccnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dot_x"}, int'(dot_x), 0);
        chk({tag, "_line_y"}, int'(line_y), 0);
        chk({tag, "_pix_ce"}, int'(pix_ce), 0);
        chk({tag, "_cpu_ce"}, int'(cpu_ce), 0);
        chk({tag, "_hsync_n"}, int'(hsync_n), 1);
        chk({tag, "_vsync_n"}, int'(vsync_n), 1);
        chk({tag, "_blank"}, int'(blank), 0);
        chk({tag, "_burst"}, int'(burst), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_odd_frame"}, int'(odd_frame), 0);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        tick_q <= master_tick;
        rst_q <= reset;
    end

    always @(negedge clk) begin
        exp_t e;
        logic [5:0] got;
        if (pq.size() > 0 && pq[0].cyc < cyc) begin
            e = pq.pop_front();
            checks++;
            fail_line("pix_missing_at_cycle", 0, e.cyc);
        end
        if (cq.size() > 0 && cq[0] < cyc) begin
            checks++;
            fail_line("cpu_missing_at_cycle", 0, cq.pop_front());
        end
        if (pix_ce) begin
            pix_total++;
            if (!hsync_n) hs_low++;
            if (burst) bu_hi++;
            if (!tick_q) idle_pix++;
            if (pq.size() == 0) begin
                checks++;
                fail_line("pix_spurious_at_cycle", cyc, -1);
            end else begin
                e = pq.pop_front();
                chk("pix_cycle", cyc, e.cyc);
                got = {hsync_n, vsync_n, blank, burst, frame_start, odd_frame};
                checks++;
                if (dot_x !== e.x || line_y !== e.y || got !== e.flags) begin
                    failures++;
                    if (nprint < 40) begin
                        $display("FAIL pix_entry cyc=%0d got x=%0d y=%0d f=%b expected x=%0d y=%0d f=%b",
                                 cyc, dot_x, line_y, got, e.x, e.y, e.flags);
                        nprint++;
                    end
                end
            end
        end
        if (cpu_ce) begin
            if (!tick_q) idle_pix++;
            if (cq.size() == 0) begin
                checks++;
                fail_line("cpu_spurious_at_cycle", cyc, -1);
            end else begin
                chk("cpu_cycle", cyc, cq.pop_front());
            end
        end
        if (rst_q) begin
            len2 = 0;
            vs2 = 0;
        end else if (s_pix) begin
            len2++;
            if (!s_vs) vs2++;
            if (s_fs) begin
                if (nfs2 < 8) begin
                    lens[nfs2] = len2;
                    vsl[nfs2] = vs2;
                    oddr[nfs2] = s_odd;
                end
                nfs2++;
                len2 = 0;
                vs2 = 0;
            end
        end
    end

    initial begin
        int base_hs, base_bu, base_p, base_i, ticks;
        logic [22:0] acc;
        logic old, t;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk_reset("rst");
        step(1'b0, 1'b0);
        chk_reset("rst_after");

        base_hs = hs_low;
        base_bu = bu_hi;
        for (int i = 0; i < 2000 && k != 341; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("line_wrap_dot_x", int'(dot_x), 0);
        chk("line_wrap_line_y", int'(line_y), 1);
        chk("hsync_low_dots", hs_low - base_hs, 25);
        chk("burst_high_dots", bu_hi - base_bu, 15);

        for (int i = 0; i < 12000 && nfs2 < 2; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("frames_seen", int'(nfs2 >= 2), 1);
        chk("even_frame_dots", lens[0], 3144);
        chk("odd_frame_dots", lens[1], 3143);
        chk("vsync_dots_f0", vsl[0], 36);
        chk("vsync_dots_f1", vsl[1], 36);
        chk("odd_after_f0", int'(oddr[0]), 1);
        chk("odd_after_f1", int'(oddr[1]), 0);

        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        base_p = pix_total;
        base_i = idle_pix;
        ticks = 0;
        acc = '0;
        for (int i = 0; i < 2000; i++) begin
            old = acc[17];
            acc = acc + 23'd57745;
            t = acc[17] & ~old;
            if (t) ticks++;
            step(t, 1'b0);
        end
        step(1'b0, 1'b0);
        chk("acc_pix_count", pix_total - base_p, ticks / 4);
        chk("idle_cycle_enables", idle_pix - base_i, 0);

        for (int i = 0; i < 701; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk_reset("midrst");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("midrst_pix_ce", int'(pix_ce), 1);
        chk("midrst_dot_x", int'(dot_x), 1);

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk_reset("coinc");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("coinc_no_early_pix", int'(pix_ce), 0);
        step(1'b1, 1'b0);
        chk("coinc_pix_ce", int'(pix_ce), 1);
        chk("coinc_dot_x", int'(dot_x), 1);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("pix_queue_drained", pq.size(), 0);
        chk("cpu_queue_drained", cq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
